rs_enc_sched: RTL and testbench

- Frame scheduler that shares one RS(10,8) GF(16) encoder core between two symbol sources.
- Grants whole 8-symbol frames with round-robin arbitration.
- Drives the core's frame-alignment (synchronous reset) and symbol input.
- Registers the core's 10-slot output stream with framing and source tags for the downstream framer.

---
 rtl/rs_pkg.sv | 19 +
 rtl/rs_rr_arb2.sv | 46 ++++
 rtl/rs_enc_sched.sv | 175 +++++++++++++++++
 tb/tb_rs_enc_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared constants, state encoding and helpers for the RS(10,8) encoder frame scheduler.
package rs_pkg;

    localparam int SYM_W   = 4;
    localparam int N_SLOTS = 10;
    localparam int K_SLOTS = 8;
    localparam int SLOT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } sched_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rs_rr_arb2.sv
// Two-request arbiter; round robin by default, fixed priority (source 0 wins)
// when RS_SCHED_FIXED_PRIO_EN is defined.
module rs_rr_arb2
    import rs_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic       win_o,
    output logic       any_o
);

    assign any_o = |req_i;

`ifdef RS_SCHED_FIXED_PRIO_EN
    logic unused_s;

    assign win_o    = ~req_i[0];
    assign unused_s = ^{clk_i, rst_i, upd_i};
`else
    logic last_q;

    // Winner selection: under contention the source not served last wins.
    always_comb begin
        win_o = 1'b0;
        if (req_i == 2'b11) begin
            win_o = ~last_q;
        end else begin
            win_o = req_i[1];
        end
    end

    // Pointer update; reset value 1 makes source 0 the first favourite.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (upd_i && any_o) begin
            last_q <= win_o;
        end else begin
            last_q <= last_q;
        end
    end
`endif

endmodule

// File: rtl/rs_enc_sched.sv
// Shares one RS(10,8) GF(16) encoder core between two sources, whole frames at a time.
// Arbitration mode selected by macro RS_SCHED_FIXED_PRIO_EN (undefined: round robin).
module rs_enc_sched
    import rs_pkg::*;
#(
    parameter int DATA_SLOTS = K_SLOTS,
    parameter int PAR_SLOTS  = N_SLOTS - K_SLOTS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       src_req,
    output logic [1:0]       src_gnt,
    input  logic [1:0]       src_valid,
    input  logic [SYM_W-1:0] src_data0,
    input  logic [SYM_W-1:0] src_data1,
    output logic [1:0]       src_ready,
    output logic             enc_sync,
    output logic [SYM_W-1:0] enc_x,
    input  logic [SYM_W-1:0] enc_y,
    output logic [SYM_W-1:0] y_data,
    output logic             y_valid,
    output logic             y_sof,
    output logic             y_eof,
    output logic             y_par,
    output logic             y_src,
    input  logic             err_clr,
    output logic [1:0]       underrun
);

    localparam logic [SLOT_W-1:0] LAST_DATA = SLOT_W'(DATA_SLOTS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DATA_SLOTS + PAR_SLOTS - 1);

    sched_state_e      state_q;
    logic [SLOT_W-1:0] slot_q;
    logic              gidx_q;
    logic [1:0]        gnt_q;
    logic [1:0]        rdy_q;
    logic              sync_q;
    logic [SYM_W-1:0]  y_data_q;
    logic              y_valid_q, y_sof_q, y_eof_q, y_par_q, y_src_q;
    logic [1:0]        underrun_q, underrun_d;

    logic              arb_upd_s, arb_win_s, arb_any_s;
    logic              sel_valid_s, active_s;
    logic [SYM_W-1:0]  sel_data_s, enc_x_s;
    logic [1:0]        ur_set_s;

    assign arb_upd_s = (state_q == IDLE) || ((state_q == PARITY) && (slot_q == LAST_SLOT));
    assign active_s  = (state_q != IDLE);

    rs_rr_arb2 u_arb (
        .clk_i (clk),
        .rst_i (reset),
        .req_i (src_req),
        .upd_i (arb_upd_s),
        .win_o (arb_win_s),
        .any_o (arb_any_s)
    );

    // Symbol path into the core and per-slot underrun detection.
    always_comb begin
        sel_valid_s = src_valid[gidx_q];
        sel_data_s  = gidx_q ? src_data1 : src_data0;
        enc_x_s     = '0;
        ur_set_s    = 2'b00;
        if (state_q == DATA) begin
            if (sel_valid_s) begin
                enc_x_s = sel_data_s;
            end else begin
                ur_set_s = onehot2(gidx_q);
            end
        end else begin
            enc_x_s  = '0;
            ur_set_s = 2'b00;
        end
        underrun_d = (underrun_q & {2{~err_clr}}) | ur_set_s;
    end

    // Frame FSM; grant, ready and core sync are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            gidx_q  <= 1'b0;
            gnt_q   <= 2'b00;
            rdy_q   <= 2'b00;
            sync_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    slot_q <= '0;
                    if (arb_any_s) begin
                        state_q <= DATA;
                        gidx_q  <= arb_win_s;
                        gnt_q   <= onehot2(arb_win_s);
                        rdy_q   <= onehot2(arb_win_s);
                        sync_q  <= 1'b0;
                    end else begin
                        gnt_q  <= 2'b00;
                        rdy_q  <= 2'b00;
                        sync_q <= 1'b1;
                    end
                end
                DATA: begin
                    slot_q <= slot_q + SLOT_W'(1);
                    if (slot_q == LAST_DATA) begin
                        state_q <= PARITY;
                        rdy_q   <= 2'b00;
                    end else begin
                        state_q <= DATA;
                    end
                end
                PARITY: begin
                    if (slot_q != LAST_SLOT) begin
                        slot_q <= slot_q + SLOT_W'(1);
                    end else if (arb_any_s) begin
                        // Back-to-back frame: the core wraps to slot 0 on its own.
                        state_q <= DATA;
                        slot_q  <= '0;
                        gidx_q  <= arb_win_s;
                        gnt_q   <= onehot2(arb_win_s);
                        rdy_q   <= onehot2(arb_win_s);
                    end else begin
                        state_q <= IDLE;
                        slot_q  <= '0;
                        gnt_q   <= 2'b00;
                        rdy_q   <= 2'b00;
                        sync_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    slot_q  <= '0;
                    gnt_q   <= 2'b00;
                    rdy_q   <= 2'b00;
                    sync_q  <= 1'b1;
                end
            endcase
        end
    end

    // Output stage and sticky underrun flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_data_q   <= '0;
            y_valid_q  <= 1'b0;
            y_sof_q    <= 1'b0;
            y_eof_q    <= 1'b0;
            y_par_q    <= 1'b0;
            y_src_q    <= 1'b0;
            underrun_q <= 2'b00;
        end else begin
            y_data_q   <= active_s ? enc_y : '0;
            y_valid_q  <= active_s;
            y_sof_q    <= (state_q == DATA) && (slot_q == '0);
            y_eof_q    <= (state_q == PARITY) && (slot_q == LAST_SLOT);
            y_par_q    <= (state_q == PARITY);
            y_src_q    <= active_s & gidx_q;
            underrun_q <= underrun_d;
        end
    end

    assign src_gnt   = gnt_q;
    assign src_ready = rdy_q;
    assign enc_sync  = sync_q;
    assign enc_x     = enc_x_s;
    assign y_data    = y_data_q;
    assign y_valid   = y_valid_q;
    assign y_sof     = y_sof_q;
    assign y_eof     = y_eof_q;
    assign y_par     = y_par_q;
    assign y_src     = y_src_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_rs_enc_sched.sv
// Directed bench for rs_enc_sched with a behavioural RS(10,8) GF(16) encoder core attached.
module tb_rs_enc_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] src_req, src_gnt, src_valid, src_ready, underrun;
    logic [3:0] src_data0, src_data1, enc_x, enc_y, y_data;
    logic       enc_sync, y_valid, y_sof, y_eof, y_par, y_src, err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rs_enc_sched dut (
        .clk       (clk),
        .reset     (reset),
        .src_req   (src_req),
        .src_gnt   (src_gnt),
        .src_valid (src_valid),
        .src_data0 (src_data0),
        .src_data1 (src_data1),
        .src_ready (src_ready),
        .enc_sync  (enc_sync),
        .enc_x     (enc_x),
        .enc_y     (enc_y),
        .y_data    (y_data),
        .y_valid   (y_valid),
        .y_sof     (y_sof),
        .y_eof     (y_eof),
        .y_par     (y_par),
        .y_src     (y_src),
        .err_clr   (err_clr),
        .underrun  (underrun)
    );

    // Encoder core: g(x) = x^2 + 6x + 8 over GF(16), x^4 + x + 1.
    logic [3:0] c_slot = 4'd0;
    logic [3:0] c_r1   = 4'd0;
    logic [3:0] c_r0   = 4'd0;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
        end
        return p;
    endfunction

    always @(posedge clk) begin
        if (enc_sync) begin
            c_slot <= 4'd0;
            c_r1   <= 4'd0;
            c_r0   <= 4'd0;
        end else begin
            if (c_slot < 4'd8) begin
                c_r1 <= c_r0 ^ gf_mul(enc_x ^ c_r1, 4'h6);
                c_r0 <= gf_mul(enc_x ^ c_r1, 4'h8);
            end else if (c_slot == 4'd9) begin
                c_r1 <= 4'd0;
                c_r0 <= 4'd0;
            end
            c_slot <= (c_slot == 4'd9) ? 4'd0 : c_slot + 4'd1;
        end
    end

    assign enc_y = (c_slot < 4'd8) ? enc_x : ((c_slot == 4'd8) ? c_r1 : c_r0);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_y(input int s, input logic src, input logic [3:0] exp_d, input logic chk_par);
        chk($sformatf("y_valid[%0d]", s), y_valid, 1);
        chk($sformatf("y_sof[%0d]", s), y_sof, (s == 0) ? 1 : 0);
        chk($sformatf("y_eof[%0d]", s), y_eof, (s == 9) ? 1 : 0);
        chk($sformatf("y_par[%0d]", s), y_par, (s >= 8) ? 1 : 0);
        chk($sformatf("y_src[%0d]", s), y_src, src);
        if (s < 8 || chk_par) chk($sformatf("y_data[%0d]", s), y_data, exp_d);
    endtask

    // Entered at the falling edge inside slot 0; leaves at the falling edge after slot 9.
    // Granted source sends 1..8, the other source sends the complement; RS parity of 1..8 is (1, 5).
    task automatic run_frame(input logic src, input int drop, input logic [1:0] req9, input logic chk_par);
        logic [3:0] exp_d [10];
        logic [3:0] d;
        for (int s = 0; s < 10; s++) begin
            d = 4'(s + 1);
            if (s < 8) begin
                src_valid = 2'b11;
                if (s == drop) src_valid[src] = 1'b0;
                src_data0 = src ? ~d : d;
                src_data1 = src ? d : ~d;
                exp_d[s]  = (s == drop) ? 4'h0 : d;
            end else begin
                src_valid = 2'b00;
                exp_d[s]  = (s == 8) ? 4'h1 : 4'h5;
            end
            if (s == 9) src_req = req9;
            #1;
            chk($sformatf("enc_sync[%0d]", s), enc_sync, 0);
            chk($sformatf("src_gnt[%0d]", s), src_gnt, src ? 2 : 1);
            chk($sformatf("src_ready[%0d]", s), src_ready, (s < 8) ? (src ? 2 : 1) : 0);
            chk($sformatf("enc_x[%0d]", s), enc_x, (s < 8) ? exp_d[s] : 4'h0);
            if (s > 0) check_y(s - 1, src, exp_d[s - 1], chk_par);
            @(negedge clk);
        end
        check_y(9, src, exp_d[9], chk_par);
    endtask

    initial begin
        logic exp_src [4];
`ifdef RS_SCHED_FIXED_PRIO_EN
        exp_src = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        reset = 1'b1; src_req = 2'b00; src_valid = 2'b00;
        src_data0 = 4'h0; src_data1 = 4'h0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst enc_sync", enc_sync, 1);
        chk("rst src_gnt", src_gnt, 0);
        chk("rst src_ready", src_ready, 0);
        chk("rst y_valid", y_valid, 0);
        chk("rst underrun", underrun, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single frame from source 0, then return to idle.
        src_req = 2'b01;
        @(negedge clk);
        src_req = 2'b00;
        run_frame(1'b0, -1, 2'b00, 1'b1);
        chk("idle enc_sync", enc_sync, 1);
        chk("idle src_gnt", src_gnt, 0);
        chk("idle underrun", underrun, 0);
        @(negedge clk);
        chk("idle y_valid", y_valid, 0);
        chk("idle y_eof", y_eof, 0);

        // Underrun: source 1 withholds slot 3.
        src_req = 2'b10;
        @(negedge clk);
        src_req = 2'b00;
        run_frame(1'b1, 3, 2'b00, 1'b0);
        chk("ur set", underrun, 2'b10);
        @(negedge clk);
        chk("ur sticky", underrun, 2'b10);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ur clear", underrun, 2'b00);

        // Contention: four back-to-back frames.
        src_req = 2'b11;
        @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            run_frame(exp_src[f], -1, (f == 3) ? 2'b00 : 2'b11, 1'b1);
        end
        chk("cont idle enc_sync", enc_sync, 1);
        chk("cont underrun", underrun, 0);

        // Reset in slot 5, then a clean frame from source 1.
        @(negedge clk);
        src_req = 2'b01;
        @(negedge clk);
        src_req = 2'b00;
        for (int s = 0; s < 5; s++) begin
            src_valid = 2'b11;
            src_data0 = 4'(s + 1);
            @(negedge clk);
        end
        chk("pre-rst y_valid", y_valid, 1);
        reset = 1'b1;
        #1;
        chk("mrst enc_sync", enc_sync, 1);
        chk("mrst src_gnt", src_gnt, 0);
        chk("mrst src_ready", src_ready, 0);
        chk("mrst enc_x", enc_x, 0);
        chk("mrst y_valid", y_valid, 0);
        chk("mrst y_data", y_data, 0);
        chk("mrst y_sof", y_sof, 0);
        chk("mrst y_eof", y_eof, 0);
        @(negedge clk);
        reset = 1'b0;
        src_req = 2'b10;
        @(negedge clk);
        src_req = 2'b00;
        run_frame(1'b1, -1, 2'b00, 1'b1);
        @(negedge clk);
        chk("end y_valid", y_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
